// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master controller: FSM states, shift-register
// modes and the shift-register next-value helper.
package spi_master_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Shift-register operating modes
    typedef enum logic [1:0] {
        PLOAD = 2'd0,
        HOLD  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } shift_mode_t;

    // Width of the SCK half-period counter; covers CLK_DIV up to 255
    localparam int unsigned CNT_W = 8;

    // Next shift-register value for a given mode; only the low 'width' bits matter
    function automatic logic [31:0] shift_next(
        input shift_mode_t mode,
        input logic [31:0] cur,
        input logic [31:0] load,
        input logic        in_bit,
        input int unsigned width
    );
        logic [31:0] res;
        unique case (mode)
            PLOAD:   res = load;
            LEFT:    res = {cur[30:0], in_bit};
            RIGHT:   res = (cur >> 1) | (32'(in_bit) << (width - 1));
            default: res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_clk_gen.sv
// SCK timing generator: counts CLK_DIV system cycles per SCK half-period and
// emits alternating one-cycle rise/fall ticks while enabled. The counter and
// phase are held cleared while disabled so every transfer starts identically.
module spi_clk_gen
    import spi_master_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;   // 0: next tick is a rising edge
    logic             w_tick;

    assign w_tick      = i_en && (r_cnt == CNT_W'(CLK_DIV - 1));
    assign o_rise_tick = w_tick && !r_phase;
    assign o_fall_tick = w_tick && r_phase;

    // Half-period counter and edge phase
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || !i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master controller: valid/ready word in, MSB-first shift out on
// mosi, miso sampled on sclk rising edges, received word pulsed on rx_valid.
// Optional build macro SPI_CTRL_LOOPBACK_EN adds a 'loopback' input that feeds
// the internal mosi back into the receive path instead of miso.
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
`ifdef SPI_CTRL_LOOPBACK_EN
    input  logic             loopback,
`endif
    output logic             cs_n
);

    localparam int unsigned BIT_W = $clog2(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic               r_sample;    // miso bit captured on the rising edge
    logic               r_sclk;
    logic               r_mosi;
    logic               r_cs_n;
    logic               r_rx_valid;
    logic [WIDTH-1:0]   r_rx_data;

    shift_mode_t        w_mode;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_rise_tick;
    logic               w_fall_tick;
    logic               w_sample_in;
    logic               w_last_bit;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_en        (r_state == SHIFT),
        .o_rise_tick (w_rise_tick),
        .o_fall_tick (w_fall_tick)
    );

`ifdef SPI_CTRL_LOOPBACK_EN
    assign w_sample_in = loopback ? r_mosi : miso;
`else
    assign w_sample_in = miso;
`endif

    assign w_last_bit = (r_bit_cnt == BIT_W'(WIDTH - 1));

    // Shift-register mode: load on handshake, shift left on each sclk fall
    always_comb begin
        w_mode = HOLD;
        case (r_state)
            IDLE:    if (tx_valid) w_mode = PLOAD;
            SHIFT:   if (w_fall_tick) w_mode = LEFT;
            default: w_mode = HOLD;
        endcase
    end

    assign w_shift_next = WIDTH'(shift_next(w_mode, 32'(r_shreg), 32'(tx_data), r_sample, WIDTH));

    // Shift register update
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shreg <= '0;
        end else begin
            r_shreg <= w_shift_next;
        end
    end

    // Controller FSM with registered SPI pins and receive outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_sample   <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_state <= LOAD;
                        r_cs_n  <= 1'b0;
                        r_mosi  <= tx_data[WIDTH-1];
                    end
                end
                LOAD: begin
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_rise_tick) begin
                        r_sclk   <= 1'b1;
                        r_sample <= w_sample_in;
                    end
                    if (w_fall_tick) begin
                        r_sclk <= 1'b0;
                        if (w_last_bit) begin
                            // Final falling edge: the shifted value is the full received word
                            r_bit_cnt  <= '0;
                            r_mosi     <= 1'b0;
                            r_cs_n     <= 1'b1;
                            r_rx_data  <= w_shift_next;
                            r_rx_valid <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_mosi    <= w_shift_next[WIDTH-1];
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a WIDTH=8/CLK_DIV=2 instance with a
// mode-0 slave model, plus a CLK_DIV=1 instance for sclk timing.
module tb_spi_master_ctrl;

    localparam int W      = 8;
    localparam int DIV    = 2;
    localparam int LAT    = 2 + 2 * W * DIV;   // handshake cycle to rx_valid cycle
    localparam int GAP    = 2 * W * DIV + 3;   // handshake to handshake when held valid
    localparam int LAT_D1 = 2 + 2 * W * 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;

    logic         tx_valid = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_ready, rx_valid, busy, sclk, mosi, cs_n;
    logic [W-1:0] rx_data;
    logic         miso = 1'b0;

    logic         tx_valid_d1 = 1'b0;
    logic [W-1:0] tx_data_d1 = '0;
    logic         tx_ready_d1, rx_valid_d1, busy_d1, sclk_d1, mosi_d1, cs_n_d1;
    logic [W-1:0] rx_data_d1;
    logic         miso_d1 = 1'b0;

`ifdef SPI_CTRL_LOOPBACK_EN
    logic         loopback = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_master_ctrl #(.WIDTH(W), .CLK_DIV(DIV)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
`ifdef SPI_CTRL_LOOPBACK_EN
        .loopback (loopback),
`endif
        .cs_n     (cs_n)
    );

    spi_master_ctrl #(.WIDTH(W), .CLK_DIV(1)) u_dut_d1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_valid (tx_valid_d1),
        .tx_data  (tx_data_d1),
        .tx_ready (tx_ready_d1),
        .rx_valid (rx_valid_d1),
        .rx_data  (rx_data_d1),
        .busy     (busy_d1),
        .sclk     (sclk_d1),
        .mosi     (mosi_d1),
        .miso     (miso_d1),
`ifdef SPI_CTRL_LOOPBACK_EN
        .loopback (1'b0),
`endif
        .cs_n     (cs_n_d1)
    );

    // Monitor: cycle count, handshakes, received words, mosi bits at sclk rise
    int           cyc = 0;
    int           hs_q[$];
    int           rxc_q[$];
    logic [W-1:0] rx_q[$];
    logic         mosi_q[$];

    // Slave model: word latched while deselected, advance one bit per sclk fall
    logic [W-1:0] slv_word = '0;
    logic [W-1:0] slv_cur = '0;
    int           slv_idx = 0;
    logic         slv_prev_sclk = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset_n && tx_valid && tx_ready) hs_q.push_back(cyc);
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            rxc_q.push_back(cyc);
        end
        if (cs_n) begin
            slv_cur = slv_word;
            slv_idx = 0;
        end else if (!sclk && slv_prev_sclk) begin
            slv_idx = slv_idx + 1;
        end
        slv_prev_sclk = sclk;
        miso = (slv_idx < W) ? slv_cur[W-1-slv_idx] : 1'b0;
    end

    always @(posedge sclk) mosi_q.push_back(mosi);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        hs_q.delete();
        rxc_q.delete();
        rx_q.delete();
        mosi_q.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk); #1;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy=%0b after 200 cycles, required 0", busy);
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c;
        c = 0;
        while (rx_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (rx_q.size() < n) begin
            errors++;
            $display("FAIL wait_rx: got %0d words, required %0d", rx_q.size(), n);
        end
    endtask

    task automatic start_xfer(input logic [W-1:0] tx, input logic [W-1:0] sw);
        wait_idle();
        @(posedge clk); #1;
        slv_word = sw;
        tx_valid = 1'b1;
        tx_data  = tx;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = W'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 7;
        if (cs_n !== 1'b1)     begin errors++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        if (sclk !== 1'b0)     begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        if (mosi !== 1'b0)     begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        if (rx_data !== '0)    begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] exp_tx;
        exp_tx = 8'hA5;
        clear_q();
        start_xfer(exp_tx, 8'h3C);
        wait_rx(1, 100);
        checks++;
        if (mosi_q.size() != W) begin
            errors++; $display("FAIL dir_mosi_count: got %0d want %0d", mosi_q.size(), W);
        end
        for (int i = 0; i < W && i < mosi_q.size(); i++) begin
            checks++;
            if (mosi_q[i] !== exp_tx[W-1-i]) begin
                errors++; $display("FAIL dir_mosi_bit%0d: got %b want %b", i, mosi_q[i], exp_tx[W-1-i]);
            end
        end
        if (rx_q.size() > 0 && hs_q.size() > 0) begin
            checks += 2;
            if (rx_q[0] !== 8'h3C) begin
                errors++; $display("FAIL dir_rx_data: got %h want 3c", rx_q[0]);
            end
            if (rxc_q[0] - hs_q[0] != LAT) begin
                errors++; $display("FAIL dir_latency: got %0d want %0d", rxc_q[0] - hs_q[0], LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] tx, sw, got_tx;
        for (int it = 0; it < 6; it++) begin
            tx = W'($urandom);
            sw = W'($urandom);
            clear_q();
            start_xfer(tx, sw);
            wait_rx(1, 100);
            got_tx = '0;
            for (int i = 0; i < W && i < mosi_q.size(); i++) got_tx[W-1-i] = mosi_q[i];
            checks += 2;
            if (got_tx !== tx || mosi_q.size() != W) begin
                errors++; $display("FAIL rnd_mosi: got %h (%0d bits) want %h", got_tx, mosi_q.size(), tx);
            end
            if (rx_q.size() == 0 || rx_q[0] !== sw) begin
                errors++; $display("FAIL rnd_rx_data: got %h want %h", (rx_q.size() > 0) ? rx_q[0] : 'x, sw);
            end
            if (rx_q.size() > 0 && hs_q.size() > 0) begin
                checks++;
                if (rxc_q[0] - hs_q[0] != LAT) begin
                    errors++; $display("FAIL rnd_latency: got %0d want %0d", rxc_q[0] - hs_q[0], LAT);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        logic [W-1:0] sws [3];
        logic [W-1:0] got_tx;
        int idx;
        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
        for (int i = 0; i < 3; i++) sws[i] = W'($urandom);
        wait_idle();
        clear_q();
        idx = 0;
        tx_valid = 1'b1;
        tx_data  = words[0];
        slv_word = sws[0];
        for (int c = 0; c < 200 && rx_q.size() < 3; c++) begin
            @(posedge clk);
            if (hs_q.size() > idx) idx = hs_q.size();
            #1;
            if (idx < 3) begin
                tx_data  = words[idx];
                slv_word = sws[idx];
            end else begin
                tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0;
        wait_rx(3, 100);
        checks++;
        if (hs_q.size() != 3) begin
            errors++; $display("FAIL b2b_handshakes: got %0d want 3", hs_q.size());
        end
        for (int i = 1; i < 3 && i < hs_q.size(); i++) begin
            checks++;
            if (hs_q[i] - hs_q[i-1] != GAP) begin
                errors++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, hs_q[i] - hs_q[i-1], GAP);
            end
        end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== sws[i]) begin
                errors++; $display("FAIL b2b_rx%0d: got %h want %h", i, rx_q[i], sws[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            got_tx = '0;
            for (int b = 0; b < W && (i * W + b) < mosi_q.size(); b++) got_tx[W-1-b] = mosi_q[i * W + b];
            checks++;
            if (got_tx !== words[i]) begin
                errors++; $display("FAIL b2b_mosi%0d: got %h want %h", i, got_tx, words[i]);
            end
        end
    endtask

    task automatic test_hold_during_shift();
        logic [W-1:0] w1, w2, s1, s2, got_tx;
        w1 = W'($urandom); w2 = W'($urandom);
        s1 = W'($urandom); s2 = W'($urandom);
        wait_idle();
        clear_q();
        tx_valid = 1'b1;
        tx_data  = w1;
        slv_word = s1;
        for (int n = 1; n <= 36; n++) begin
            @(posedge clk); #1;
            if (n <= LAT) begin
                checks++;
                if (tx_ready !== 1'b0) begin
                    errors++; $display("FAIL hold_tx_ready_c%0d: got %b want 0", n, tx_ready);
                end
            end else if (n == LAT + 1) begin
                checks++;
                if (tx_ready !== 1'b1) begin
                    errors++; $display("FAIL hold_first_idle_ready: got %b want 1", tx_ready);
                end
            end
            if (n < LAT) tx_data = W'($urandom);
            else if (n == LAT) begin
                tx_data  = w2;
                slv_word = s2;
            end
            if (n == LAT + 2) tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        wait_rx(2, 100);
        checks++;
        if (hs_q.size() != 2 || hs_q[1] - hs_q[0] != GAP) begin
            errors++; $display("FAIL hold_handshakes: got %0d handshakes want 2 spaced %0d", hs_q.size(), GAP);
        end
        for (int i = 0; i < 2; i++) begin
            got_tx = '0;
            for (int b = 0; b < W && (i * W + b) < mosi_q.size(); b++) got_tx[W-1-b] = mosi_q[i * W + b];
            checks++;
            if (got_tx !== ((i == 0) ? w1 : w2)) begin
                errors++; $display("FAIL hold_mosi%0d: got %h want %h", i, got_tx, (i == 0) ? w1 : w2);
            end
        end
        if (rx_q.size() >= 2) begin
            checks += 2;
            if (rx_q[0] !== s1) begin errors++; $display("FAIL hold_rx0: got %h want %h", rx_q[0], s1); end
            if (rx_q[1] !== s2) begin errors++; $display("FAIL hold_rx1: got %h want %h", rx_q[1], s2); end
        end
    endtask

    task automatic test_abort();
        int c;
        clear_q();
        start_xfer(W'($urandom), W'($urandom));
        c = 0;
        while (mosi_q.size() < 3 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks += 6;
        if (cs_n !== 1'b1)     begin errors++; $display("FAIL abort_cs_n: got %b want 1", cs_n); end
        if (sclk !== 1'b0)     begin errors++; $display("FAIL abort_sclk: got %b want 0", sclk); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL abort_tx_ready: got %b want 1", tx_ready); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (rx_data !== '0)    begin errors++; $display("FAIL abort_rx_data: got %h want 00", rx_data); end
        if (mosi_q.size() != 3) begin errors++; $display("FAIL abort_rises: got %0d want 3", mosi_q.size()); end
        repeat (80) @(posedge clk);
        #1;
        checks += 2;
        if (rx_q.size() != 0) begin errors++; $display("FAIL abort_rx_pulse: got %0d pulses want 0", rx_q.size()); end
        if (mosi_q.size() != 3) begin errors++; $display("FAIL abort_late_rises: got %0d want 3", mosi_q.size()); end
    endtask

    task automatic test_clk_div1();
        int   n_rise, last_rise, bad_gap, done_n;
        logic prev;
        n_rise = 0; last_rise = -1; bad_gap = 0; done_n = -1; prev = 1'b0;
        @(posedge clk); #1;
        tx_valid_d1 = 1'b1;
        tx_data_d1  = W'($urandom);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) begin
                checks++;
                if (tx_ready_d1 !== 1'b1) begin
                    errors++; $display("FAIL d1_ready: got %b want 1", tx_ready_d1);
                end
            end
            if (!cs_n_d1 && sclk_d1 && !prev) begin
                if (last_rise >= 0 && n - last_rise != 2) bad_gap++;
                last_rise = n;
                n_rise++;
            end
            prev = sclk_d1;
            if (rx_valid_d1) begin
                done_n = n;
                checks += 2;
                if (cs_n_d1 !== 1'b1) begin errors++; $display("FAIL d1_done_cs_n: got %b want 1", cs_n_d1); end
                if (sclk_d1 !== 1'b0) begin errors++; $display("FAIL d1_done_sclk: got %b want 0", sclk_d1); end
            end
            if (n == 0) begin
                @(posedge clk); #1;
                tx_valid_d1 = 1'b0;
            end
        end
        checks += 3;
        if (n_rise != W)      begin errors++; $display("FAIL d1_rises: got %0d want %0d", n_rise, W); end
        if (bad_gap != 0)     begin errors++; $display("FAIL d1_period: got %0d bad periods want 0", bad_gap); end
        if (done_n != LAT_D1) begin errors++; $display("FAIL d1_latency: got %0d want %0d", done_n, LAT_D1); end
    endtask

`ifdef SPI_CTRL_LOOPBACK_EN
    task automatic test_loopback();
        clear_q();
        loopback = 1'b1;
        start_xfer(8'h5A, 8'h00);
        wait_rx(1, 100);
        loopback = 1'b0;
        checks++;
        if (rx_q.size() == 0 || rx_q[0] !== 8'h5A) begin
            errors++; $display("FAIL loopback_rx: got %h want 5a", (rx_q.size() > 0) ? rx_q[0] : 'x);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_hold_during_shift();
        test_abort();
        test_clk_div1();
`ifdef SPI_CTRL_LOOPBACK_EN
        test_loopback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving bits per transfer (legal values 2..32).
REQ-002 SHALL have parameter CLK_DIV, default 4, giving clk cycles per SCK half-period (legal values 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port tx_valid, input, 1 bit: a transmit word is offered.
REQ-006 SHALL have port tx_data, input, WIDTH bits: the word to send, MSB first.
REQ-007 SHALL have port tx_ready, output, 1 bit: the controller can accept a word.
REQ-008 SHALL have port rx_valid, output, 1 bit: one-cycle pulse marking a received word.
REQ-009 SHALL have port rx_data, output, WIDTH bits: the last received word.
REQ-010 SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-011 SHALL have port sclk, output, 1 bit: SPI serial clock (mode 0, idles low).
REQ-012 SHALL have port mosi, output, 1 bit: serial data out.
REQ-013 SHALL have port miso, input, 1 bit: serial data in.
REQ-014 SHALL have port cs_n, output, 1 bit: chip select, active-low.

Function
REQ-015 SHALL use a state machine with states IDLE, LOAD, SHIFT and DONE.
REQ-016 SHALL assert tx_ready exactly when in IDLE; a handshake is tx_valid && tx_ready at a clk edge.
REQ-017 On a handshake, SHALL parallel-load tx_data into the internal shift register and move to LOAD.
REQ-018 LOAD lasts 1 cycle: cs_n low, sclk low, mosi = tx_data[WIDTH-1]; then the FSM moves to SHIFT.
REQ-019 SHIFT SHALL toggle sclk every CLK_DIV cycles, for WIDTH rising and WIDTH falling edges (2*WIDTH*CLK_DIV cycles in total).
REQ-020 SHALL sample miso into the shift register LSB on each sclk rising edge, and shift left / present the next MSB on mosi on each sclk falling edge.
REQ-021 After the final falling edge, SHALL enter DONE for 1 cycle: cs_n high, rx_data = received word, rx_valid = 1; then the FSM moves to IDLE.
REQ-022 Latency SHALL be exactly 2 + 2*WIDTH*CLK_DIV cycles from the handshake edge to the cycle in which rx_valid is high.
REQ-023 rx_data SHALL hold its value until the next DONE; rx_valid has no backpressure.
REQ-024 tx_valid outside IDLE SHALL be ignored, including when coincident with DONE; such a word is accepted on the first IDLE cycle.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 A BIT counter SHALL wrap cleanly, with no extra edge or glitch on sclk at the start or end of a transfer.
REQ-027 Back-to-back transfers SHALL have a cs_n high gap of at least 2 cycles (DONE + IDLE).

Reset
REQ-028 While reset_n = 0 at a clk edge, the block SHALL enter IDLE with cs_n = 1, sclk = 0, mosi = 0, rx_valid = 0, rx_data = 0, busy = 0 and the counters cleared.
REQ-029 Reset during LOAD, SHIFT or DONE SHALL abort the transfer with no rx_valid pulse, and tx_ready SHALL be 1 on the first cycle after reset is released.

Configuration
REQ-030 With macro SPI_CTRL_LOOPBACK_EN defined, the block SHALL add input port loopback (1 bit); when loopback = 1 the sampled input is the internal mosi and miso is ignored.
REQ-031 Without SPI_CTRL_LOOPBACK_EN, the loopback port SHALL be absent and miso SHALL always be sampled.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding and the shift-register mode constants PLOAD, HOLD, LEFT and RIGHT.
REQ-033 The single sub-module spi_clk_gen SHALL hold the CLK_DIV counter and emit one-cycle rise_tick and fall_tick pulses while enabled.

Verification
REQ-034 With WIDTH=8, CLK_DIV=2, tx_data=0xA5 and a slave model returning 0x3C, the bench SHALL check mosi bits 1,0,1,0,0,1,0,1, rx_data=0x3C and rx_valid exactly 34 cycles after the handshake.
REQ-035 With CLK_DIV=1, the bench SHALL check sclk has a period of 2 cycles, exactly 8 rising edges while cs_n = 0, and cs_n high in DONE.
REQ-036 With tx_valid held high for 3 words 0x01, 0x80, 0xFF, the bench SHALL check 3 handshakes, each separated by the full transfer plus 2 cycles, and 3 rx_valid pulses in order.
REQ-037 With reset_n pulsed low after the 3rd sclk rising edge, the bench SHALL check no rx_valid pulse, cs_n = 1, sclk = 0 and tx_ready = 1 on the next cycle.
REQ-038 With SPI_CTRL_LOOPBACK_EN defined, loopback = 1, miso held at 0 and tx_data = 0x5A, the bench SHALL check rx_data = 0x5A.
REQ-039 With tx_valid asserted during SHIFT, the bench SHALL check that tx_ready = 0 and tx_data changes do not affect the in-flight mosi stream.
